// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with a block-RAM storage array, registered read data,
// full/empty flags decoded from a registered occupancy count, optional COUNT.
module synchronous_fifo #(
  parameter int C_WIDTH         = 256,
  parameter int C_DEPTH         = 512,
  parameter int C_PROVIDE_COUNT = 0,
  localparam int C_ADDR_RAW     = $clog2(C_DEPTH),
  localparam int C_CAP          = 1 << C_ADDR_RAW,
  localparam int C_DEPTH_WIDTH  = $clog2(C_CAP + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [C_WIDTH-1:0]       WR_DATA,
  output logic                     FULL,
  output logic [C_DEPTH_WIDTH-1:0] COUNT,
  input  logic                     RD_EN,
  output logic [C_WIDTH-1:0]       RD_DATA,
  output logic                     EMPTY
);

  // A depth of one still needs a one-bit pointer; it simply never leaves zero.
  localparam int C_AW = (C_ADDR_RAW < 1) ? 1 : C_ADDR_RAW;

  localparam logic [C_AW-1:0]          PTR_ZERO = {C_AW{1'b0}};
  localparam logic [C_AW-1:0]          PTR_ONE  = C_AW'(1);
  localparam logic [C_AW-1:0]          PTR_MAX  = C_AW'(C_CAP - 1);
  localparam logic [C_DEPTH_WIDTH-1:0] CNT_ZERO = {C_DEPTH_WIDTH{1'b0}};
  localparam logic [C_DEPTH_WIDTH-1:0] CNT_ONE  = C_DEPTH_WIDTH'(1);
  localparam logic [C_DEPTH_WIDTH-1:0] CNT_CAP  = C_DEPTH_WIDTH'(C_CAP);

  logic [C_WIDTH-1:0]       mem_r [C_CAP];
  logic [C_AW-1:0]          wptr_r;
  logic [C_AW-1:0]          rptr_r;
  logic [C_DEPTH_WIDTH-1:0] cnt_r;
  logic [C_WIDTH-1:0]       rd_data_r;
  logic                     full_s;
  logic                     empty_s;
  logic                     wr_accept_s;
  logic                     rd_accept_s;
  logic [C_AW-1:0]          wptr_next_s;
  logic [C_AW-1:0]          rptr_next_s;

  // Acceptance is judged only on the flags held at the sampling edge.
  always_comb begin
    full_s      = (cnt_r == CNT_CAP);
    empty_s     = (cnt_r == CNT_ZERO);
    wr_accept_s = WR_EN && !full_s;
    rd_accept_s = RD_EN && !empty_s;
    if (wptr_r == PTR_MAX) begin
      wptr_next_s = PTR_ZERO;
    end else begin
      wptr_next_s = wptr_r + PTR_ONE;
    end
    if (rptr_r == PTR_MAX) begin
      rptr_next_s = PTR_ZERO;
    end else begin
      rptr_next_s = rptr_r + PTR_ONE;
    end
  end

  // Storage array: no reset so it maps onto block RAM; reset-cycle writes are dropped.
  always_ff @(posedge CLK) begin
    if (RST && wr_accept_s) begin
      mem_r[wptr_r] <= WR_DATA;
    end
  end

  // Registered read port; holds its value when no read is accepted.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_data_r <= {C_WIDTH{1'b0}};
    end else if (rd_accept_s) begin
      rd_data_r <= mem_r[rptr_r];
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wptr_r <= PTR_ZERO;
      rptr_r <= PTR_ZERO;
      cnt_r  <= CNT_ZERO;
    end else begin
      if (wr_accept_s) begin
        wptr_r <= wptr_next_s;
      end
      if (rd_accept_s) begin
        rptr_r <= rptr_next_s;
      end
      case ({wr_accept_s, rd_accept_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign FULL    = full_s;
  assign EMPTY   = empty_s;
  assign RD_DATA = rd_data_r;

  generate
    if (C_PROVIDE_COUNT == 1) begin : g_count
      assign COUNT = cnt_r;
    end else begin : g_no_count
      assign COUNT = CNT_ZERO;
    end
  endgenerate

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed self-checking bench: a 512-deep counting FIFO and a 3-deep
// (rounded to 4) FIFO with the count output disabled.
module tb_synchronous_fifo;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [255:0] wr_data;
  logic         full;
  logic [9:0]   count;
  logic         rd_en;
  logic [255:0] rd_data;
  logic         empty;

  logic         wr_en_b;
  logic [7:0]   wr_data_b;
  logic         full_b;
  logic [2:0]   count_b;
  logic         rd_en_b;
  logic [7:0]   rd_data_b;
  logic         empty_b;

  int checks;
  int errors;

  synchronous_fifo #(.C_WIDTH(256), .C_DEPTH(512), .C_PROVIDE_COUNT(1)) dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .FULL(full),
    .COUNT(count), .RD_EN(rd_en), .RD_DATA(rd_data), .EMPTY(empty)
  );

  synchronous_fifo #(.C_WIDTH(8), .C_DEPTH(3), .C_PROVIDE_COUNT(0)) dut_b (
    .CLK(clk), .RST(rst), .WR_EN(wr_en_b), .WR_DATA(wr_data_b), .FULL(full_b),
    .COUNT(count_b), .RD_EN(rd_en_b), .RD_DATA(rd_data_b), .EMPTY(empty_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    wr_en     = 1'b1;
    rd_en     = 1'b1;
    wr_data   = 256'h77;
    wr_en_b   = 1'b1;
    rd_en_b   = 1'b1;
    wr_data_b = 8'h77;

    // Reset with both enables high
    tick();
    tick();
    check("rst_empty", 256'(empty), 256'd1);
    check("rst_full", 256'(full), 256'd0);
    check("rst_count", 256'(count), 256'd0);
    check("rst_rd_data", rd_data, 256'd0);
    check("rst_b_empty", 256'(empty_b), 256'd1);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0;
    tick();
    check("post_rst_count", 256'(count), 256'd0);

    // Basic order
    wr_en = 1'b1;
    wr_data = 256'h11; tick(); check("basic_cnt1", 256'(count), 256'd1);
    check("basic_not_empty", 256'(empty), 256'd0);
    wr_data = 256'h22; tick(); check("basic_cnt2", 256'(count), 256'd2);
    wr_data = 256'h33; tick(); check("basic_cnt3", 256'(count), 256'd3);
    wr_en = 1'b0; rd_en = 1'b1;
    tick(); check("basic_rd1", rd_data, 256'h11); check("basic_cnt_r2", 256'(count), 256'd2);
    tick(); check("basic_rd2", rd_data, 256'h22); check("basic_cnt_r1", 256'(count), 256'd1);
    tick(); check("basic_rd3", rd_data, 256'h33); check("basic_cnt_r0", 256'(count), 256'd0);
    check("basic_empty", 256'(empty), 256'd1);

    // Underflow: read while empty holds data; same-cycle write not fall-through
    tick();
    check("uf_hold", rd_data, 256'h33);
    check("uf_count", 256'(count), 256'd0);
    wr_en = 1'b1; wr_data = 256'h5;
    tick();
    check("uf_wr_count", 256'(count), 256'd1);
    check("uf_no_fallthru", rd_data, 256'h33);
    wr_en = 1'b0;
    tick();
    check("uf_rd5", rd_data, 256'h5);
    check("uf_count0", 256'(count), 256'd0);
    rd_en = 1'b0;

    // Fill to capacity, overflow attempt, full simultaneous rd/wr
    wr_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      wr_data = 256'(i);
      tick();
    end
    check("full_flag", 256'(full), 256'd1);
    check("full_count", 256'(count), 256'd512);
    check("full_not_empty", 256'(empty), 256'd0);
    wr_data = 256'hDEAD;
    tick();
    check("ovf_count", 256'(count), 256'd512);
    rd_en = 1'b1; wr_data = 256'hBEEF;
    tick();
    check("full_rw_count", 256'(count), 256'd511);
    check("full_rw_data", rd_data, 256'd0);
    check("full_rw_not_full", 256'(full), 256'd0);
    wr_en = 1'b0;
    for (int i = 1; i < 512; i++) begin
      tick();
      check("drain_data", rd_data, 256'(i));
    end
    check("drain_empty", 256'(empty), 256'd1);
    check("drain_count", 256'(count), 256'd0);
    rd_en = 1'b0;

    // Sustained simultaneous read/write across pointer wrap
    wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr_data = 256'(1000 + i);
      tick();
    end
    check("wrap_fill_count", 256'(count), 256'd256);
    rd_en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      wr_data = 256'(5000 + k);
      tick();
      check("wrap_count", 256'(count), 256'd256);
      if (k < 256) check("wrap_data_a", rd_data, 256'(1000 + k));
      else         check("wrap_data_b", rd_data, 256'(5000 + k - 256));
    end
    wr_en = 1'b0;
    for (int j = 0; j < 256; j++) begin
      tick();
      check("wrap_drain", rd_data, 256'(5000 + 744 + j));
    end
    check("wrap_empty", 256'(empty), 256'd1);
    rd_en = 1'b0;

    // Reset mid-transfer discards stored words
    wr_en = 1'b1; wr_data = 256'hAA;
    tick(); tick();
    check("mid_pre_count", 256'(count), 256'd2);
    rst = 1'b0; rd_en = 1'b1;
    tick();
    check("mid_rst_count", 256'(count), 256'd0);
    check("mid_rst_empty", 256'(empty), 256'd1);
    check("mid_rst_rd_data", rd_data, 256'd0);
    rst = 1'b1; wr_en = 1'b0;
    tick();
    check("mid_rst_hold", rd_data, 256'd0);
    rd_en = 1'b0;

    // Count disabled, depth 3 rounds up to 4
    wr_en_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data_b = 8'(8'hA0 + i);
      tick();
      check("b_count_zero", 256'(count_b), 256'd0);
      check("b_not_empty", 256'(empty_b), 256'd0);
      check("b_full", 256'(full_b), (i == 3) ? 256'd1 : 256'd0);
    end
    wr_data_b = 8'hEE;
    tick();
    check("b_ovf_full", 256'(full_b), 256'd1);
    wr_en_b = 1'b0; rd_en_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_data", 256'(rd_data_b), 256'(8'hA0 + i));
      check("b_count_zero_rd", 256'(count_b), 256'd0);
    end
    check("b_empty", 256'(empty_b), 256'd1);
    check("b_not_full", 256'(full_b), 256'd0);
    rd_en_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
